// File: rtl/spi_prog_loader.sv
// spi_prog_loader: parses a host SPI byte stream (opcode 0x01 + 4 address bytes, opcode 0x02 + 4 data bytes,
// MSB first) into 32-bit word writes toward boot/instruction memory.
// Latency: wr_valid rises 1 cycle after the last data byte strobe; with wr_ready=1 the write completes that cycle.
// Backpressure: rx bytes cannot be stalled; one byte arriving while a write waits is held, further bytes are dropped (overflow).
// Ports: clk, reset (sync, active-high); rx_byte/rx_valid in; wr_addr/wr_data/wr_valid out, wr_ready in;
//        busy, err_cmd, err_range, overflow (sticky) and checksum out.
// Optional feature: define SPI_LOADER_CKSUM_EN to accumulate completed write data into checksum (otherwise tied to 0).
`timescale 1ns/1ps

module spi_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          MEM_BYTES = 8192,
    parameter logic [7:0]  OP_ADDR   = 8'h01,
    parameter logic [7:0]  OP_DATA   = 8'h02
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        busy,
    output logic        err_cmd,
    output logic        err_range,
    output logic        overflow,
    output logic [31:0] checksum
);

    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic [31:0] addr_reg, addr_n;
    logic [31:0] data_reg, data_n;
    logic        hold_vld, hold_vld_n;
    logic [7:0]  hold_dat, hold_dat_n;
    logic        set_cmd, set_range, set_ovf;

    logic        byte_vld;
    logic [7:0]  byte_in;
    logic [31:0] word_addr;
    logic [31:0] win_off;
    logic        in_range;
    logic        wr_fire;

    assign word_addr = {addr_reg[31:2], 2'b00};
    // Offset into the window; a wrapped or below-base address gives a huge offset and fails the check.
    assign win_off   = word_addr - BASE_ADDR;
    assign in_range  = ((win_off >> AW) == 32'd0);

    assign wr_valid  = (state == WRITE);
    assign wr_fire   = wr_valid & wr_ready;
    // Address/data are only presented while a write is pending so idle outputs stay 0.
    assign wr_addr   = wr_valid ? word_addr : 32'd0;
    assign wr_data   = wr_valid ? data_reg  : 32'd0;
    assign busy      = (state != IDLE) | hold_vld;

    // The held byte always has priority over a fresh strobe so stream order is preserved.
    assign byte_in   = hold_vld ? hold_dat : rx_byte;
    assign byte_vld  = (state != WRITE) & (hold_vld | rx_valid);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        addr_n     = addr_reg;
        data_n     = data_reg;
        hold_vld_n = hold_vld;
        hold_dat_n = hold_dat;
        set_cmd    = 1'b0;
        set_range  = 1'b0;
        set_ovf    = 1'b0;

        // Holding register: filled while a write waits; drained first once parsing resumes.
        if (state == WRITE) begin
            if (rx_valid) begin
                if (!hold_vld) begin
                    hold_vld_n = 1'b1;
                    hold_dat_n = rx_byte;
                end else begin
                    set_ovf = 1'b1;
                end
            end
        end else if (hold_vld) begin
            // Entry is consumed this cycle; a simultaneous strobe refills it.
            hold_vld_n = rx_valid;
            if (rx_valid) begin
                hold_dat_n = rx_byte;
            end
        end

        case (state)
            IDLE: begin
                if (byte_vld) begin
                    if (byte_in == OP_ADDR) begin
                        state_n = ADDR;
                        cnt_n   = 2'd3;
                    end else if (byte_in == OP_DATA) begin
                        state_n = DATA;
                        cnt_n   = 2'd3;
                    end else begin
                        set_cmd = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (byte_vld) begin
                    addr_n = {addr_reg[23:0], byte_in};
                    cnt_n  = cnt - 2'd1;
                    if (cnt == 2'd0) begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (byte_vld) begin
                    data_n = {data_reg[23:0], byte_in};
                    cnt_n  = cnt - 2'd1;
                    if (cnt == 2'd0) begin
                        if (in_range) begin
                            state_n = WRITE;
                        end else begin
                            set_range = 1'b1;
                            addr_n    = addr_reg + 32'd4;
                            state_n   = IDLE;
                        end
                    end
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    addr_n  = addr_reg + 32'd4;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            addr_reg  <= BASE_ADDR;
            data_reg  <= 32'd0;
            hold_vld  <= 1'b0;
            hold_dat  <= 8'd0;
            err_cmd   <= 1'b0;
            err_range <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            addr_reg  <= addr_n;
            data_reg  <= data_n;
            hold_vld  <= hold_vld_n;
            hold_dat  <= hold_dat_n;
            err_cmd   <= err_cmd   | set_cmd;
            err_range <= err_range | set_range;
            overflow  <= overflow  | set_ovf;
        end
    end

`ifdef SPI_LOADER_CKSUM_EN
    logic [31:0] cksum_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cksum_reg <= 32'd0;
        end else if (wr_fire) begin
            cksum_reg <= cksum_reg + data_reg;
        end
    end

    assign checksum = cksum_reg;
`else
    logic unused_fire;
    assign unused_fire = wr_fire;
    assign checksum    = 32'h0;
`endif

endmodule

// File: tb/tb_spi_prog_loader.sv
`timescale 1ns/1ps

module tb_spi_prog_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        busy;
    logic        err_cmd;
    logic        err_range;
    logic        overflow;
    logic [31:0] checksum;

    int total = 0;
    int bad   = 0;

    spi_prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .err_cmd   (err_cmd),
        .err_range (err_range),
        .overflow  (overflow),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected just after the following clock edge.
    // flags = {err_cmd, err_range, overflow}
    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        rdy;
        logic        e_wv;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_busy;
        logic [2:0]  e_flags;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [7:0] b, input logic rdy, input logic e_wv,
                       input logic [31:0] e_addr, input logic [31:0] e_data, input logic e_busy,
                       input logic [2:0] e_flags);
        vec_t r;
        r.v = v; r.b = b; r.rdy = rdy; r.e_wv = e_wv; r.e_addr = e_addr;
        r.e_data = e_data; r.e_busy = e_busy; r.e_flags = e_flags;
        tbl.push_back(r);
    endtask

    // Inputs are driven 1ns after a rising edge; outputs are sampled 1ns after the next one.
    task automatic step(input string name, input logic v, input logic [7:0] b, input logic rdy,
                        input logic e_wv, input logic [31:0] e_addr, input logic [31:0] e_data,
                        input logic e_busy, input logic [2:0] e_flags);
        logic [2:0] flags;
        rx_valid = v;
        rx_byte  = b;
        wr_ready = rdy;
        @(posedge clk);
        #1;
        flags = {err_cmd, err_range, overflow};
        total++;
        if (wr_valid !== e_wv || wr_addr !== e_addr || wr_data !== e_data ||
            busy !== e_busy || flags !== e_flags) begin
            bad++;
            $display("FAIL %s: got wv=%0b addr=%h data=%h busy=%0b flags=%b, want wv=%0b addr=%h data=%h busy=%0b flags=%b",
                     name, wr_valid, wr_addr, wr_data, busy, flags, e_wv, e_addr, e_data, e_busy, e_flags);
        end
    endtask

    task automatic check_cksum(input string name, input logic [31:0] exp);
        total++;
        if (checksum !== exp) begin
            bad++;
            $display("FAIL %s: got checksum=%h, want %h", name, checksum, exp);
        end
    endtask

    task automatic run_table(input string name, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            step($sformatf("%s[%0d]", name, i - lo), tbl[i].v, tbl[i].b, tbl[i].rdy, tbl[i].e_wv,
                 tbl[i].e_addr, tbl[i].e_data, tbl[i].e_busy, tbl[i].e_flags);
        end
    endtask

    logic [31:0] cksum_t12;
    int sec_b, sec_c, sec_end;

    initial begin
`ifdef SPI_LOADER_CKSUM_EN
        cksum_t12 = 32'hDEAD_BF02;
`else
        cksum_t12 = 32'h0;
`endif
        // ---- section A: basic address + data write, wr_ready high
        add(1, 8'h01, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h10, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h00, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h00, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h00, 1, 0, 0, 0, 0, 3'b000);
        add(1, 8'h02, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hDE, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hAD, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hBE, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hEF, 1, 1, 32'h1000_0000, 32'hDEAD_BEEF, 1, 3'b000);
        add(0, 8'h00, 1, 0, 0, 0, 0, 3'b000);
        sec_b = tbl.size();
        // ---- section B: out-of-window write, then unknown opcode, then reload address
        add(1, 8'h01, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h20, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h00, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h00, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h00, 1, 0, 0, 0, 0, 3'b000);
        add(1, 8'h02, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h11, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h22, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h33, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h44, 1, 0, 0, 0, 0, 3'b010);
        add(1, 8'h02, 1, 0, 0, 0, 1, 3'b010);
        add(1, 8'h00, 1, 0, 0, 0, 1, 3'b010);
        add(1, 8'h00, 1, 0, 0, 0, 1, 3'b010);
        add(1, 8'h00, 1, 0, 0, 0, 1, 3'b010);
        add(1, 8'h01, 1, 0, 0, 0, 0, 3'b010);
        add(1, 8'h7F, 1, 0, 0, 0, 0, 3'b110);
        add(1, 8'h01, 1, 0, 0, 0, 1, 3'b110);
        add(1, 8'h10, 1, 0, 0, 0, 1, 3'b110);
        add(1, 8'h00, 1, 0, 0, 0, 1, 3'b110);
        add(1, 8'h00, 1, 0, 0, 0, 1, 3'b110);
        add(1, 8'h08, 1, 0, 0, 0, 0, 3'b110);
        add(1, 8'h02, 1, 0, 0, 0, 1, 3'b110);
        add(1, 8'hCA, 1, 0, 0, 0, 1, 3'b110);
        add(1, 8'hFE, 1, 0, 0, 0, 1, 3'b110);
        add(1, 8'h00, 1, 0, 0, 0, 1, 3'b110);
        add(1, 8'h01, 1, 1, 32'h1000_0008, 32'hCAFE_0001, 1, 3'b110);
        add(0, 8'h00, 1, 0, 0, 0, 0, 3'b110);
        sec_c = tbl.size();
        // ---- section C: last word of the window writes, the next one is out of range
        add(1, 8'h01, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h10, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h00, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'h1F, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hFC, 1, 0, 0, 0, 0, 3'b000);
        add(1, 8'h02, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hA1, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hA2, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hA3, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hA4, 1, 1, 32'h1000_1FFC, 32'hA1A2_A3A4, 1, 3'b000);
        add(0, 8'h00, 1, 0, 0, 0, 0, 3'b000);
        add(1, 8'h02, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hB1, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hB2, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hB3, 1, 0, 0, 0, 1, 3'b000);
        add(1, 8'hB4, 1, 0, 0, 0, 0, 3'b010);
        sec_end = tbl.size();

        // ---- reset
        reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step("reset_state", 0, 8'h00, 0, 0, 0, 0, 0, 3'b000);
        check_cksum("reset_cksum", 32'h0);

        run_table("t1", 0, sec_b);

        // ---- test 2: sequential word, wr_ready low for 5 cycles
        step("t2_op", 1, 8'h02, 0, 0, 0, 0, 1, 3'b000);
        step("t2_b0", 1, 8'h00, 0, 0, 0, 0, 1, 3'b000);
        step("t2_b1", 1, 8'h00, 0, 0, 0, 0, 1, 3'b000);
        step("t2_b2", 1, 8'h00, 0, 0, 0, 0, 1, 3'b000);
        step("t2_b3", 1, 8'h13, 0, 1, 32'h1000_0004, 32'h0000_0013, 1, 3'b000);
        for (int i = 0; i < 5; i++)
            step($sformatf("t2_hold%0d", i), 0, 8'h00, 0, 1, 32'h1000_0004, 32'h0000_0013, 1, 3'b000);
        step("t2_done", 0, 8'h00, 1, 0, 0, 0, 0, 3'b000);
        check_cksum("t12_cksum", cksum_t12);

        run_table("t34", sec_b, sec_c);

        // ---- test 5: bytes during a stalled write (addr_reg now 0x1000_000C)
        step("t5_op", 1, 8'h02, 0, 0, 0, 0, 1, 3'b110);
        step("t5_b0", 1, 8'h00, 0, 0, 0, 0, 1, 3'b110);
        step("t5_b1", 1, 8'h00, 0, 0, 0, 0, 1, 3'b110);
        step("t5_b2", 1, 8'h00, 0, 0, 0, 0, 1, 3'b110);
        step("t5_b3", 1, 8'h55, 0, 1, 32'h1000_000C, 32'h0000_0055, 1, 3'b110);
        step("t5_held", 1, 8'h01, 0, 1, 32'h1000_000C, 32'h0000_0055, 1, 3'b110);
        step("t5_drop1", 1, 8'hAA, 0, 1, 32'h1000_000C, 32'h0000_0055, 1, 3'b111);
        step("t5_drop2", 1, 8'hBB, 0, 1, 32'h1000_000C, 32'h0000_0055, 1, 3'b111);
        step("t5_hs", 0, 8'h00, 1, 0, 0, 0, 1, 3'b111);
        // held 0x01 consumed while 0x10 arrives and refills the entry
        step("t5_drain", 1, 8'h10, 1, 0, 0, 0, 1, 3'b111);
        step("t5_refill", 0, 8'h00, 1, 0, 0, 0, 1, 3'b111);
        step("t5_a1", 1, 8'h00, 1, 0, 0, 0, 1, 3'b111);
        step("t5_a2", 1, 8'h00, 1, 0, 0, 0, 1, 3'b111);
        step("t5_a3", 1, 8'h20, 1, 0, 0, 0, 0, 3'b111);
        step("t5_dop", 1, 8'h02, 1, 0, 0, 0, 1, 3'b111);
        step("t5_d0", 1, 8'h00, 1, 0, 0, 0, 1, 3'b111);
        step("t5_d1", 1, 8'h00, 1, 0, 0, 0, 1, 3'b111);
        step("t5_d2", 1, 8'h00, 1, 0, 0, 0, 1, 3'b111);
        step("t5_d3", 1, 8'h77, 1, 1, 32'h1000_0020, 32'h0000_0077, 1, 3'b111);
        step("t5_end", 0, 8'h00, 1, 0, 0, 0, 0, 3'b111);

        // ---- test 6: reset mid data payload
        step("t6_op", 1, 8'h02, 1, 0, 0, 0, 1, 3'b111);
        step("t6_b0", 1, 8'hAA, 1, 0, 0, 0, 1, 3'b111);
        step("t6_b1", 1, 8'hBB, 1, 0, 0, 0, 1, 3'b111);
        reset = 1'b1;
        step("t6_reset", 0, 8'h00, 1, 0, 0, 0, 0, 3'b000);
        check_cksum("t6_cksum", 32'h0);
        reset = 1'b0;
        step("t6_idle", 0, 8'h00, 1, 0, 0, 0, 0, 3'b000);
        step("t6_op2", 1, 8'h02, 1, 0, 0, 0, 1, 3'b000);
        step("t6_c0", 1, 8'h12, 1, 0, 0, 0, 1, 3'b000);
        step("t6_c1", 1, 8'h34, 1, 0, 0, 0, 1, 3'b000);
        step("t6_c2", 1, 8'h56, 1, 0, 0, 0, 1, 3'b000);
        step("t6_c3", 1, 8'h78, 1, 1, 32'h1000_0000, 32'h1234_5678, 1, 3'b000);
        step("t6_end", 0, 8'h00, 1, 0, 0, 0, 0, 3'b000);

        run_table("win", sec_c, sec_end);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
